led_out_arbiter: RTL and testbench

//  Final stage in front of the 8 board LEDs. Merges the housekeeping LED register

---
 rtl/led_pkg.sv | 11 +
 rtl/led_pwm_gen.sv | 43 ++++
 rtl/led_out_arbiter.sv | 106 ++++++++++
 tb/tb_led_out_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and widths for the LED output arbiter slice.
package led_pkg;
    localparam int LED_W   = 8;
    localparam int PHASE_W = 8;

    typedef enum logic [1:0] {
        LED_NORMAL = 2'd0,
        LED_ALERT  = 2'd1,
        LED_HOLD   = 2'd2
    } led_state_e;
endpackage

// File: rtl/led_pwm_gen.sv
// PWM generator: prescaled phase counter plus duty latch that only updates at the
// period boundary so a duty change never produces a truncated or doubled pulse.
module led_pwm_gen
    import led_pkg::*;
#(
    parameter int PWM_DIV = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [PHASE_W-1:0] duty_i,
    output logic               pwm_on_o
);
    localparam int                 PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(PWM_DIV - 1);
    localparam logic [PHASE_W-1:0] PH_MAX  = {PHASE_W{1'b1}};

    logic [PRE_W-1:0]   pre_q,   pre_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] duty_q,  duty_d;
    logic               wrap;

    always_comb begin
        wrap    = (pre_q == PRE_MAX);
        pre_d   = wrap ? '0 : pre_q + PRE_W'(1);
        phase_d = wrap ? phase_q + PHASE_W'(1) : phase_q;
        duty_d  = (wrap && (phase_q == PH_MAX)) ? duty_i : duty_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre_q   <= '0;
            phase_q <= '0;
            duty_q  <= '0;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            duty_q  <= duty_d;
        end
    end

    // Full-scale duty must stay lit on phase 255 too, which the compare alone misses.
    assign pwm_on_o = (duty_q == PH_MAX) | (phase_q < duty_q);
endmodule

// File: rtl/led_out_arbiter.sv
// Merges housekeeping LEDs (PWM dimmed) with the alert stream; alerts win at full
// brightness and linger HOLD_CYC clocks after drive drops. Outputs registered, 1 clk.
module led_out_arbiter
    import led_pkg::*;
#(
    parameter int PWM_DIV  = 16,
    parameter int HOLD_CYC = 125_000_000,
    parameter int HOLD_W   = 27
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [LED_W-1:0] hk_led_i,
    input  logic [7:0]       pwm_duty_i,
    input  logic             alert_drive_i,
    input  logic [LED_W-1:0] alert_data_i,
    input  logic             alert_clr_i,
    output logic [LED_W-1:0] led_o,
    output logic             alert_active_o,
    output logic             alert_seen_o
);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);

    led_state_e        state_q,  state_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic [LED_W-1:0]  latch_q,  latch_d;
    logic [LED_W-1:0]  led_q,    led_d;
    logic              active_q, active_d;
    logic              seen_q,   seen_d;
    logic              pwm_on;

    led_pwm_gen #(
        .PWM_DIV (PWM_DIV)
    ) u_pwm (
        .clk      (clk),
        .resetn   (resetn),
        .duty_i   (pwm_duty_i),
        .pwm_on_o (pwm_on)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        latch_d = latch_q;
        seen_d  = seen_q;
        case (state_q)
            LED_NORMAL: begin
                if (alert_drive_i) begin
                    state_d = LED_ALERT;
                    latch_d = alert_data_i;
                end
            end
            LED_ALERT: begin
                if (alert_drive_i) begin
                    latch_d = alert_data_i;
                end else begin
                    state_d = LED_HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            LED_HOLD: begin
                if (alert_drive_i) begin
                    state_d = LED_ALERT;
                    latch_d = alert_data_i;
                    hold_d  = '0;
                end else if (hold_q == '0) begin
                    state_d = LED_NORMAL;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = LED_NORMAL;
        endcase

        // A fresh alert entry beats a coincident clear so no alert goes unreported.
        if ((state_d == LED_ALERT) && (state_q != LED_ALERT)) begin
            seen_d = 1'b1;
        end else if (alert_clr_i) begin
            seen_d = 1'b0;
        end

        active_d = (state_d != LED_NORMAL);
        led_d    = active_d ? latch_d : (hk_led_i & {LED_W{pwm_on}});
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= LED_NORMAL;
            hold_q   <= '0;
            latch_q  <= '0;
            led_q    <= '0;
            active_q <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            latch_q  <= latch_d;
            led_q    <= led_d;
            active_q <= active_d;
            seen_q   <= seen_d;
        end
    end

    assign led_o          = led_q;
    assign alert_active_o = active_q;
    assign alert_seen_o   = seen_q;
endmodule

// File: tb/tb_led_out_arbiter.sv
// Self-checking bench for led_out_arbiter: tables, directed corner sequences and
// random traffic, all compared against a cycle-count based reference model.
module tb_led_out_arbiter;
    localparam int PWM_DIV  = 1;
    localparam int HOLD_CYC = 8;
    localparam int HOLD_W   = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] hk, duty, data;
    logic       drive, clr;
    logic [7:0] led;
    logic       act, seen;

    int total = 0;
    int bad   = 0;

    // Reference model: time since the last drive-high sample decides alert
    // visibility; PWM phase is simply the cycle count since reset.
    int         m_n, m_since, m_duty_eff;
    logic [7:0] m_latch, m_led;
    logic       m_prev, m_seen, m_act;

    typedef struct {
        logic       drive;
        logic [7:0] data;
        logic [7:0] led;
        logic       act;
        logic       seen;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    led_out_arbiter #(
        .PWM_DIV  (PWM_DIV),
        .HOLD_CYC (HOLD_CYC),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .hk_led_i       (hk),
        .pwm_duty_i     (duty),
        .alert_drive_i  (drive),
        .alert_data_i   (data),
        .alert_clr_i    (clr),
        .led_o          (led),
        .alert_active_o (act),
        .alert_seen_o   (seen)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_step();
        int   phase;
        logic on;
        if (!resetn) begin
            m_n = 0; m_duty_eff = 0; m_since = HOLD_CYC + 1;
            m_prev = 1'b0; m_seen = 1'b0; m_latch = '0; m_led = '0; m_act = 1'b0;
        end else begin
            phase = (m_n / PWM_DIV) % 256;
            on    = (m_duty_eff == 255) || (phase < m_duty_eff);
            if (drive && !m_prev) m_seen = 1'b1;
            else if (clr)         m_seen = 1'b0;
            if (drive) begin
                m_since = 0;
                m_latch = data;
            end else if (m_since <= HOLD_CYC) begin
                m_since++;
            end
            m_act = (m_since <= HOLD_CYC);
            m_led = m_act ? m_latch : (hk & {8{on}});
            if (((m_n + 1) % (256 * PWM_DIV)) == 0) m_duty_eff = duty;
            m_n++;
            m_prev = drive;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_led",    led,  m_led);
        chk("model_active", act,  m_act);
        chk("model_seen",   seen, m_seen);
    endtask

    task automatic align_period();
        for (int i = 0; i < 600 && (m_n % 256) != 0; i++) tick();
        chk("period_align", m_n % 256, 0);
    endtask

    task automatic count_on(input int cycles, inout int cnt_on, inout int cnt_off);
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (led === 8'hA5) cnt_on++;
            else if (led === 8'h00) cnt_off++;
        end
    endtask

    initial begin
        int on_c, off_c;

        for (int i = 0; i < 16; i++) begin
            if (i < 5)       tbl[i] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1};
            else if (i == 5) tbl[i] = '{1'b1, 8'h2A, 8'h2A, 1'b1, 1'b1};
            else if (i < 14) tbl[i] = '{1'b0, 8'h00, 8'h2A, 1'b1, 1'b1};
            else             tbl[i] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        end

        // Reset with every input active
        resetn = 1'b0; hk = 8'hFF; duty = 8'hFF; drive = 1'b1; data = 8'h55; clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_led",    led,  8'h00);
            chk("reset_active", act,  1'b0);
            chk("reset_seen",   seen, 1'b0);
        end
        resetn = 1'b1; drive = 1'b0; clr = 1'b0; hk = 8'hA5; duty = 8'd64;
        tick();
        chk("release_active", act, 1'b0);
        chk("release_led",    led, 8'h00);

        // PWM brightness at 64, 255 and 0
        align_period();
        on_c = 0; off_c = 0; count_on(256, on_c, off_c);
        chk("pwm64_on", on_c, 64);
        chk("pwm64_off", off_c, 192);
        duty = 8'd255; tick(); align_period();
        on_c = 0; off_c = 0; count_on(256, on_c, off_c);
        chk("pwm255_on", on_c, 256);
        duty = 8'd0; tick(); align_period();
        on_c = 0; off_c = 0; count_on(256, on_c, off_c);
        chk("pwm0_off", off_c, 256);

        // Duty change mid-period only takes effect at the next period
        duty = 8'd64; tick(); align_period();
        on_c = 0; off_c = 0; count_on(10, on_c, off_c);
        duty = 8'd200;
        count_on(246, on_c, off_c);
        chk("dutychg_cur", on_c, 64);
        on_c = 0; off_c = 0; count_on(256, on_c, off_c);
        chk("dutychg_next", on_c, 200);

        // Alert table: hk dark so NORMAL output is 0
        hk = 8'h00; clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive = tbl[i].drive; data = tbl[i].data;
            tick();
            chk("tbl_led",    led,  tbl[i].led);
            chk("tbl_active", act,  tbl[i].act);
            chk("tbl_seen",   seen, tbl[i].seen);
        end

        // Re-entry during hold at counter value 3
        drive = 1'b1; data = 8'hC3; tick();
        drive = 1'b0; data = 8'h00;
        for (int i = 0; i < 5; i++) tick();
        drive = 1'b1; data = 8'h11; tick();
        chk("reentry_led",    led,  8'h11);
        chk("reentry_active", act,  1'b1);
        chk("reentry_seen",   seen, 1'b1);
        drive = 1'b0; data = 8'h00;
        for (int i = 0; i < HOLD_CYC; i++) begin
            tick();
            chk("rehold_led",    led, 8'h11);
            chk("rehold_active", act, 1'b1);
        end
        tick();
        chk("rehold_end", act, 1'b0);

        // Set beats clear, then clear alone, then reset in HOLD
        drive = 1'b1; clr = 1'b1; data = 8'h5A; tick();
        chk("set_wins", seen, 1'b1);
        drive = 1'b0; tick();
        chk("clr_only", seen, 1'b0);
        clr = 1'b0; tick(); tick();
        chk("in_hold", act, 1'b1);
        resetn = 1'b0; tick();
        chk("hold_rst_led",    led, 8'h00);
        chk("hold_rst_active", act, 1'b0);
        resetn = 1'b1; tick();
        chk("post_rst_normal", act, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            resetn = ($urandom_range(0, 299) != 0);
            if (drive) drive = ($urandom_range(0, 3) != 0);
            else       drive = ($urandom_range(0, 19) == 0);
            data = 8'($urandom);
            clr  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) hk   = 8'($urandom);
            if ($urandom_range(0, 63) == 0) duty = 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
